imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 192 +++++++++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory as 32-bit words.
// Bytes arrive little-endian; every fourth accepted byte triggers a one-cycle
// write. The processor is held while a load is in progress, and a running
// XOR of the written words is kept for integrity checking by software.
module imem_loader #(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          cpu_hold,
  output logic          done,
  output logic [31:0]   checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  state_t        state_r;
  state_t        state_next_s;
  logic [1:0]    byte_idx_r;
  logic [AW-1:0] addr_r;
  logic [AW:0]   count_r;
  logic [31:0]   word_r;
  logic [31:0]   checksum_r;
  logic [AW-1:0] wa_r;
  logic [31:0]   wd_r;
  logic          we_r;
  logic          byte_ready_r;
  logic          cpu_hold_r;
  logic          done_r;

  logic          accept_s;
  logic          last_word_s;
  logic [31:0]   assembled_s;

  // Place one byte into its little-endian lane of a partially built word.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  // Fold one written word into the running XOR checksum.
  function automatic logic [31:0] fold_checksum(input logic [31:0] acc,
                                                input logic [31:0] word);
    return acc ^ word;
  endfunction

  // byte_ready_r mirrors "state is RECV", so a handshake is just ready & valid.
  assign accept_s    = byte_ready_r & byte_valid;
  // Words written so far equals addr+1 while in WRITE; compare at count width.
  assign last_word_s = (({1'b0, addr_r} + {{AW{1'b0}}, 1'b1}) == count_r);
  assign assembled_s = insert_byte(word_r, byte_idx_r, byte_data);

  // Next-state decode for the load sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (word_count != {(AW+1){1'b0}}) begin
            state_next_s = RECV;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RECV: begin
        if (accept_s && (byte_idx_r == 2'd3)) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = RECV;
        end
      end
      WRITE: begin
        if (last_word_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RECV;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus output flags registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      byte_ready_r <= 1'b0;
      we_r         <= 1'b0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      byte_ready_r <= (state_next_s == RECV);
      we_r         <= (state_next_s == WRITE);
      cpu_hold_r   <= (state_next_s != IDLE);
      done_r       <= (state_next_s == DONE);
    end
  end

  // Datapath: byte assembly, address/count bookkeeping, write port, checksum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_r <= 2'd0;
      addr_r     <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      word_r     <= 32'd0;
      checksum_r <= 32'd0;
      wa_r       <= {AW{1'b0}};
      wd_r       <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            checksum_r <= 32'd0;
            if (word_count != {(AW+1){1'b0}}) begin
              byte_idx_r <= 2'd0;
              addr_r     <= {AW{1'b0}};
              if (word_count > DEPTH_W) begin
                count_r <= DEPTH_W;
              end else begin
                count_r <= word_count;
              end
            end
          end
        end
        RECV: begin
          if (accept_s) begin
            word_r     <= assembled_s;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              // Present the completed word on the write port for WRITE.
              wa_r <= addr_r;
              wd_r <= assembled_s;
            end
          end
        end
        WRITE: begin
          checksum_r <= fold_checksum(checksum_r, wd_r);
          // Address advances only when another word follows, so it never wraps.
          if (!last_word_s) begin
            addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          byte_idx_r <= 2'd0;
        end
        default: begin
          byte_idx_r <= 2'd0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign we         = we_r;
  assign wa         = wa_r;
  assign wd         = wd_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign checksum   = checksum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of load scenarios driven by a
// byte-streaming task, plus hand-written reset and mid-load-abort sequences.
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          cpu_hold;
  logic          done;
  logic [31:0]   checksum;

  imem_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int wc;        // word_count driven with start
    int gap;       // idle cycles between accepted bytes
    bit use_prog;  // first 12 bytes come from the reference program
    bit spam;      // pulse start during the load and on the DONE cycle
    int exp_words; // number of writes expected
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] prog [12];
  logic [7:0] bytes_buf [256];
  logic [31:0] exp_w [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Run one complete load and compare writes, timing, checksum and idle state.
  task automatic run_load(input int seed, input int wc, input int gap,
                          input bit use_prog, input bit spam, input int n,
                          input string tag);
    int          total;
    int          bi;
    int          wr;
    int          cyc;
    int          gcnt;
    int          hold_err;
    int          ready_err;
    int          budget;
    bit          seen_done;
    logic [31:0] exp_ck;
    total = 4 * n;
    for (int i = 0; i < total; i++) begin
      if (use_prog && i < 12) bytes_buf[i] = prog[i];
      else bytes_buf[i] = 8'((i * 37 + 11 + seed) & 255);
    end
    exp_ck = 32'd0;
    for (int w = 0; w < n; w++) begin
      exp_w[w] = {bytes_buf[4*w+3], bytes_buf[4*w+2], bytes_buf[4*w+1], bytes_buf[4*w]};
      exp_ck   = exp_ck ^ exp_w[w];
    end
    bi = 0; wr = 0; cyc = 0; gcnt = 0; hold_err = 0; ready_err = 0; seen_done = 1'b0;
    budget = 20 * (n + 1) * (gap + 1) + 20;

    @(negedge clk);
    start = 1'b1; word_count = wc[AW:0]; byte_valid = 1'b0;
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      // sample outputs settled from the previous rising edge
      if (!cpu_hold) hold_err++;
      if (gap > 0 && gcnt > 0 && (bi % 4) != 0 && !byte_ready) ready_err++;
      if (we) begin
        if (wr < n) begin
          check({tag, " wa"}, 32'(wa), 32'(wr));
          check({tag, " wd"}, wd, exp_w[wr]);
        end
        wr++;
      end
      if (done) seen_done = 1'b1;
      // drive inputs for the next rising edge
      start = (spam && ((cyc % 7 == 0) || seen_done)) ? 1'b1 : 1'b0;
      word_count = spam ? 7'd1 : wc[AW:0];
      if (bi < total && gcnt == 0) begin
        byte_valid = 1'b1;
        byte_data  = bytes_buf[bi];
        if (byte_ready) begin
          bi++;
          gcnt = gap;
        end
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom_range(0, 255));
        if (gcnt > 0) gcnt--;
      end
    end
    check({tag, " done seen"}, 32'(seen_done), 32'd1);
    check({tag, " writes"}, 32'(wr), 32'(n));
    check({tag, " checksum"}, checksum, exp_ck);
    check({tag, " hold"}, 32'(hold_err), 32'd0);
    if (gap == 0) check({tag, " done cycle"}, 32'(cyc), 32'(5 * n + 1));
    else check({tag, " ready in gaps"}, 32'(ready_err), 32'd0);

    // one cycle after done: back in IDLE even if start was pulsed on DONE
    @(negedge clk);
    check({tag, " idle hold"}, 32'(cpu_hold), 32'd0);
    check({tag, " idle flags"}, {29'd0, done, we, byte_ready}, 32'd0);
    if (n > 0) check({tag, " wa held"}, 32'(wa), 32'(n - 1));
    check({tag, " checksum held"}, checksum, exp_ck);
    start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int bi;
    int cyc;
    int wr;
    int bad;
    prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
             8'hB3, 8'h81, 8'h20, 8'h00};
    vecs[0] = '{wc: 3,   gap: 0, use_prog: 1'b1, spam: 1'b0, exp_words: 3};
    vecs[1] = '{wc: 3,   gap: 3, use_prog: 1'b1, spam: 1'b0, exp_words: 3};
    vecs[2] = '{wc: 0,   gap: 0, use_prog: 1'b0, spam: 1'b1, exp_words: 0};
    vecs[3] = '{wc: 64,  gap: 0, use_prog: 1'b0, spam: 1'b1, exp_words: 64};
    vecs[4] = '{wc: 100, gap: 0, use_prog: 1'b0, spam: 1'b0, exp_words: 64};
    vecs[5] = '{wc: 1,   gap: 1, use_prog: 1'b0, spam: 1'b1, exp_words: 1};
    vecs[6] = '{wc: 5,   gap: 2, use_prog: 1'b0, spam: 1'b1, exp_words: 5};

    reset_n = 1'b0; start = 1'b0; word_count = 7'd0; byte_valid = 1'b0; byte_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", {27'd0, byte_ready, we, cpu_hold, done, 1'b0}, 32'd0);
    check("reset wa", 32'(wa), 32'd0);
    check("reset wd", wd, 32'd0);
    check("reset checksum", checksum, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {29'd0, byte_ready, we, cpu_hold}, 32'd0);

    // Reference program: expected words are the little-endian packing of prog.
    check("prog word0", {prog[3], prog[2], prog[1], prog[0]}, 32'h00500093);

    for (int v = 0; v < 7; v++) begin
      run_load(v * 13, vecs[v].wc, vecs[v].gap, vecs[v].use_prog, vecs[v].spam,
               vecs[v].exp_words, $sformatf("vec%0d", v));
    end

    // Mid-load reset: 6 of 12 bytes, then asynchronous reset between edges.
    @(negedge clk);
    start = 1'b1; word_count = 7'd3;
    bi = 0; cyc = 0; wr = 0;
    while (bi < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (we) wr++;
      byte_valid = 1'b1;
      byte_data  = prog[bi];
      if (byte_ready) bi++;
    end
    check("abort bytes sent", 32'(bi), 32'd6);
    @(negedge clk);
    byte_data = prog[6];
    #2;
    reset_n = 1'b0;
    #1;
    check("abort writes before reset", 32'(wr), 32'd1);
    check("abort async flags", {28'd0, byte_ready, we, cpu_hold, done}, 32'd0);
    check("abort async wa", 32'(wa), 32'd0);
    check("abort async wd", wd, 32'd0);
    check("abort async checksum", checksum, 32'd0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (we || cpu_hold) bad++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      byte_data = prog[(c + 6) % 12];
      if (we || cpu_hold || byte_ready) bad++;
    end
    check("abort no further writes", 32'(bad), 32'd0);
    byte_valid = 1'b0;
    run_load(0, 3, 0, 1'b1, 1'b0, 3, "reload");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
